decimal_bcd_encoder_core: RTL and testbench
===========================================

Name: decimal_bcd_encoder_core

Overview:
- Registered 10-line decimal-to-BCD priority encoder.
- Converts a decimal digit line vector (bit k = digit k) into a 4-bit BCD code.
- The highest asserted line wins.
- Sits between keypad/digit-select logic and BCD datapath or display logic; outputs are registered for clean timing.

Parameters:
- N_IN, 10, number of decimal input lines; must be 2..16.
- OUT_W, 4, BCD output width; must be >= ceil(log2(N_IN)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  N_IN  decimal line vector; bit k asserted = digit k requested.
- out  output  OUT_W  BCD code of the highest asserted line (registered).
- valid  output  1  1 when any input line was asserted at the last sampling edge.
- err  output  1  input-error flag; see Optional Feature.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All outputs are driven from flops on clk.
- Reset:
  - While rst_n=0: out=0, valid=0, err=0, applied immediately without waiting for a clock edge.
  - Release takes effect at the first rising clk edge after rst_n rises.
- Latency: exactly 1 cycle. On each rising edge, in is sampled and out/valid/err reflect that sample until the next edge. No handshake; in is sampled every cycle.
- Encoding: out = index of the most significant asserted bit of in.
  - Example: in=10'b0000001010 gives out=3.
  - Example: in=10'b1000000001 gives out=9.
- Zero input (in=0): out=0, valid=0. A genuine digit-0 request (in=10'b1) gives out=0, valid=1. valid distinguishes the two cases.
- Multi-hot input is not illegal. The priority rule always applies and valid=1.
- Output values never exceed N_IN-1; codes 10..15 are never produced with default parameters.
- Reset mid-operation: outputs clear asynchronously; the first sample after release is encoded normally.
- No internal state other than the output registers.
- The next-state logic must be purely combinational.

Optional Feature:
- Macro: DECIMAL_BCD_ENCODER_ERR_EN.
- Defined:
  - err is registered with the same 1-cycle latency as out.
  - err=1 when the sampled in has zero bits set or more than one bit set. Otherwise err=0.
  - out and valid behave exactly as without the macro.
- Not defined:
  - err is constant 0, including during reset.
  - The port still exists so that port lists do not change between builds.
  - No one-hot checking logic is synthesized.

Decomposition:
- Package decimal_bcd_pkg holds:
  - constants DBE_N_IN=10 and DBE_OUT_W=4;
  - typedef dbe_lines_t (logic [DBE_N_IN-1:0]);
  - typedef bcd_t (logic [DBE_OUT_W-1:0]).
- One sub-module, dbe_prio_enc, does the combinational work:
  - inputs: lines;
  - outputs: code, any, multi;
  - descending-index priority scan.
- The top module instantiates dbe_prio_enc and holds the output flops plus the err logic under the macro.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in=10'b1000000000 -> out=0, valid=0, err=0 immediately. Release, then one edge later -> out=9, valid=1.
- One-hot sweep: for k=0..9, in=1<<k -> one cycle later out=k, valid=1, err=0. Checks 10'b0000000001->0, 10'b0000100000->5, 10'b1000000000->9.
- Multi-hot priority: in=10'b0000001010 -> out=3, valid=1. in=10'b1000000001 -> out=9, valid=1. With ERR_EN, err=1 for both; without it, err=0.
- Zero input: in=0 -> out=0, valid=0. With ERR_EN, err=1.
- Latency/back-to-back: change in every cycle through 1, 512, 32, 10, 513 -> out sequence 0, 9, 5, 3, 9, each appearing exactly one edge after its input.
- Random: 1000 random 10-bit vectors checked against a reference model giving the highest set index, valid = |in, and err = (popcount != 1) when ERR_EN is defined.

Source files
------------

// File: rtl/decimal_bcd_pkg.sv
// Shared constants and types for the decimal-to-BCD priority encoder.
package decimal_bcd_pkg;
  localparam int DBE_N_IN  = 10;
  localparam int DBE_OUT_W = 4;

  typedef logic [DBE_N_IN-1:0]  dbe_lines_t;
  typedef logic [DBE_OUT_W-1:0] bcd_t;
endpackage

// File: rtl/dbe_prio_enc.sv
// Combinational priority scan: highest asserted line wins; flags any/multi-hot.
module dbe_prio_enc #(
  parameter int N_IN     = 10,
  parameter int OUT_W    = 4,
  parameter bit MULTI_EN = 1'b1
) (
  input  logic [N_IN-1:0]  lines,
  output logic [OUT_W-1:0] code,
  output logic             any,
  output logic             multi
);
  logic found;
  logic extra;

  always_comb begin
    code  = '0;
    found = 1'b0;
    extra = 1'b0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (lines[i]) begin
        if (!found) begin
          code  = OUT_W'(i);
          found = 1'b1;
        end else begin
          extra = 1'b1;
        end
      end
    end
  end

  assign any = found;

  // Multi-hot detection only exists when the caller consumes it.
  generate
    if (MULTI_EN) begin : g_multi
      assign multi = extra;
    end else begin : g_nomulti
      assign multi = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/decimal_bcd_encoder_core.sv
// Registered 10-line decimal-to-BCD priority encoder, 1-cycle latency.
// Define DECIMAL_BCD_ENCODER_ERR_EN to enable the registered zero/multi-hot err flag.
module decimal_bcd_encoder_core
  import decimal_bcd_pkg::*;
#(
  parameter int N_IN  = DBE_N_IN,
  parameter int OUT_W = DBE_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             err
);
  logic [OUT_W-1:0] code;
  logic             any;

`ifdef DECIMAL_BCD_ENCODER_ERR_EN
  localparam bit MULTI_EN = 1'b1;
  logic multi;
`else
  localparam bit MULTI_EN = 1'b0;
  logic unused_multi;
`endif

  dbe_prio_enc #(
    .N_IN    (N_IN),
    .OUT_W   (OUT_W),
    .MULTI_EN(MULTI_EN)
  ) u_prio (
    .lines(in),
    .code (code),
    .any  (any),
`ifdef DECIMAL_BCD_ENCODER_ERR_EN
    .multi(multi)
`else
    .multi(unused_multi)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      out   <= code;
      valid <= any;
    end
  end

`ifdef DECIMAL_BCD_ENCODER_ERR_EN
  // Error when the sample is not exactly one-hot (zero or several lines).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= ~any | multi;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_decimal_bcd_encoder_core.sv
// Directed + random bench for decimal_bcd_encoder_core against an arithmetic model.
module tb_decimal_bcd_encoder_core;
  logic       clk;
  logic       rst_n;
  logic [9:0] in;
  logic [3:0] out;
  logic       valid;
  logic       err;

  int vectors;
  int miscompares;

  decimal_bcd_encoder_core dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .out  (out),
    .valid(valid),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the highest set bit is floor(log2(v)).
  function automatic int ref_code(input int v);
    return (v == 0) ? 0 : $clog2(v + 1) - 1;
  endfunction

  function automatic logic ref_err(input logic [9:0] v);
`ifdef DECIMAL_BCD_ENCODER_ERR_EN
    return ($countones(v) != 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input int e_out, input logic e_valid, input logic e_err);
    vectors++;
    assert (out === 4'(e_out)) else begin
      miscompares++;
      $error("FAIL %s out: got %0d want %0d", tag, out, e_out);
    end
    assert (valid === e_valid) else begin
      miscompares++;
      $error("FAIL %s valid: got %b want %b", tag, valid, e_valid);
    end
    assert (err === e_err) else begin
      miscompares++;
      $error("FAIL %s err: got %b want %b", tag, err, e_err);
    end
  endtask

  // Drive on the falling edge, check just after the next rising edge.
  task automatic step(input string tag, input logic [9:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
    check(tag, ref_code(int'(v)), |v, ref_err(v));
  endtask

  initial begin
    logic [9:0] seq [5];
    int         exp_seq [5];
    logic [9:0] r;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in          = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", 0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    in    = 10'b1000000000;
    @(posedge clk);
    #1;
    check("first_after_release", 9, 1'b1, 1'b0);

    // Async reset mid-cycle must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_release", 9, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      step($sformatf("onehot_%0d", k), 10'(1 << k));
      assert (out === 4'(k)) else begin
        miscompares++;
        $error("FAIL onehot_abs_%0d: got %0d want %0d", k, out, k);
      end
      vectors++;
    end

    step("multi_0000001010", 10'b0000001010);
    step("multi_1000000001", 10'b1000000001);
    step("zero_input", 10'b0);
    step("all_ones", 10'h3ff);

    // Back-to-back: each result appears exactly one edge after its input.
    seq     = '{10'd1, 10'd512, 10'd32, 10'd10, 10'd513};
    exp_seq = '{0, 9, 5, 3, 9};
    for (int i = 0; i < 5; i++) begin
      step($sformatf("b2b_%0d", i), seq[i]);
      assert (out === 4'(exp_seq[i])) else begin
        miscompares++;
        $error("FAIL b2b_abs_%0d: got %0d want %0d", i, out, exp_seq[i]);
      end
      vectors++;
    end

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 10'(1 << $urandom_range(0, 9));
        1:       r = '0;
        default: r = 10'($urandom_range(0, 1023));
      endcase
      step("random", r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
